atm_display_driver: RTL and testbench
=====================================

Name: atm_display_driver

Overview:
- Downstream output stage of the ATM controller FSM.
- Consumes the FSM's balance, seg_value, preview_active and beep outputs.
- Drives a 4-digit common-anode seven-segment display and a buzzer.
- Converts the 8-bit balance to decimal with a sequential double-dabble engine, time-multiplexes the digits, and stretches single-cycle beep pulses into audible buzzer bursts.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is driven before advancing (legal: ≥2).
- BEEP_CYCLES, 10000000, buzzer on-time in clk cycles per beep rising edge (legal: ≥1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- balance  input  8  unsigned account balance, 0–255.
- seg_value  input  4  preview mode code.
- preview_active  input  1  1 = show preview screen, 0 = show balance.
- beep  input  1  beep request; may be a single-cycle pulse.
- an  output  4  digit enables, active-low; an[0] = rightmost digit.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; constant 1.
- buzzer  output  1  buzzer drive, active-high.
- conv_busy  output  1  1 while a BCD conversion is in progress.

Behaviour:
- Reset (asynchronous): an=4'b1111, seg=7'b1111111, dp=1, buzzer=0, conv_busy=0.
  - digit_idx=0, refresh counter=0.
  - Converter in CONV_IDLE; BCD display regs = 0; last-converted source = 0.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1. At terminal count it clears and digit_idx increments, wrapping 3→0.
  - an and seg are registered and update on the same edge, so they are never misaligned.
  - an = ~(4'b0001 << digit_idx).
  - First active digit is digit 0, driven from the first clk edge after reset release.
- Glyphs (seg):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - P=0001100, dash=0111111, blank=1111111.
- Content, preview_active=1:
  - Digit 3 = P; digits 2,1 = blank.
  - Digit 0 = seg_value if ≤9, else dash.
  - Content is selected combinationally each scan slot; mode switches take effect at the next registered seg update.
- Content, preview_active=0:
  - Digit 3 = blank; digits 2/1/0 = hundreds/tens/ones from the BCD display regs.
- Converter FSM:
  - CONV_IDLE: if balance ≠ last-converted source, load balance into an 8-bit shift reg, clear the 12-bit BCD accumulator, set conv_busy=1, go to CONV_SHIFT.
  - CONV_SHIFT: 8 iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥5, then shifts {bcd,bin} left by 1. After the 8th iteration go to CONV_DONE.
  - CONV_DONE: copy the BCD accumulator into the display regs, record the source, clear conv_busy, return to CONV_IDLE.
- Latency: a balance change sampled in CONV_IDLE reaches the display regs 10 cycles later.
- Balance changing during CONV_SHIFT/CONV_DONE is ignored for the current conversion. The new value is detected in CONV_IDLE and converted next.
- Display regs hold their old value until CONV_DONE, so no partial values are ever shown.
- Reset mid-conversion aborts the conversion: display regs return to 0, conv_busy=0.
- Beep stretcher:
  - beep is registered to detect its rising edge.
  - A rising edge loads the counter with BEEP_CYCLES. buzzer = (counter ≠ 0), and the counter decrements while nonzero.
  - buzzer rises 1 cycle after the edge and stays high exactly BEEP_CYCLES cycles.
  - A new rising edge while active reloads the counter, extending the burst.
  - beep held high produces only one burst.

Optional Feature:
- Macro: ATM_DISP_ZERO_BLANK_EN.
- Defined, in balance mode only:
  - Hundreds digit blank when hundreds=0.
  - Tens digit blank when hundreds=0 and tens=0.
  - Ones digit always shown.
- Undefined: all three balance digits always shown, including leading zeros.
- Preview screen is unaffected either way.

Test Plan:
- Reset release, balance=0, REFRESH_DIV=4 → conv_busy stays 0; an cycles 1110,1101,1011,0111,1110, 4 cycles each; digits 2..0 show 0 (blank for digits 2,1 with macro); digit 3 blank.
- balance 0→200 → conv_busy high 9 cycles; display regs =2,0,0 at cycle 10; scan shows seg 0100100,1000000,1000000 on digits 2,1,0.
- preview_active=1, seg_value=3 → digit 3 = 0001100, digits 2,1 blank, digit 0 = 0110000; seg_value=12 → digit 0 = 0111111.
- BEEP_CYCLES=5, 1-cycle beep pulse → buzzer high exactly 5 cycles starting 1 cycle after the pulse; second pulse at buzzer cycle 3 → 5 further cycles from the reload.
- balance 255, then 7 during CONV_SHIFT → display shows 255, then 7 (with macro: digits 2,1 blank, digit 0 = 7) after a second conversion.
- Assert rst during CONV_SHIFT → all outputs at reset values immediately; after release balance reconverts (if nonzero).

Source files
------------

// File: rtl/atm_display_driver_if.sv
// atm_display_driver_if: bundles the ATM FSM outputs consumed by the display
// driver together with the display/buzzer drive signals it produces.
//   balance        8  unsigned account balance (master -> slave)
//   seg_value      4  preview mode code (master -> slave)
//   preview_active 1  1 = preview screen, 0 = balance (master -> slave)
//   beep           1  beep request, may be one cycle (master -> slave)
//   an             4  digit enables, active-low, an[0] = rightmost (slave -> master)
//   seg            7  cathodes {g,f,e,d,c,b,a}, active-low (slave -> master)
//   dp             1  decimal point, active-low, always off (slave -> master)
//   buzzer         1  buzzer drive, active-high (slave -> master)
//   conv_busy      1  BCD conversion in progress (slave -> master)
interface atm_display_driver_if;
  localparam int unsigned BAL_W = 8;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned SEG_W = 7;

  logic [BAL_W-1:0]  balance;
  logic [CODE_W-1:0] seg_value;
  logic              preview_active;
  logic              beep;
  logic [DIGITS-1:0] an;
  logic [SEG_W-1:0]  seg;
  logic              dp;
  logic              buzzer;
  logic              conv_busy;

  modport master (
    output balance, seg_value, preview_active, beep,
    input  an, seg, dp, buzzer, conv_busy
  );

  modport slave (
    input  balance, seg_value, preview_active, beep,
    output an, seg, dp, buzzer, conv_busy
  );
endinterface

// File: rtl/atm_display_driver.sv
// atm_display_driver: output stage of the ATM controller.
//   - converts the 8-bit balance to BCD with a sequential double-dabble engine
//   - time-multiplexes a 4-digit common-anode seven-segment display
//   - stretches beep pulses into BEEP_CYCLES-long buzzer bursts
// Ports: clk, rst (async, active-high), bus (atm_display_driver_if.slave).
// Parameters: REFRESH_DIV (cycles per digit, >=2), BEEP_CYCLES (>=1).
// Optional: define ATM_DISP_ZERO_BLANK_EN to blank leading zeros of the balance.
module atm_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BEEP_CYCLES = 10000000
) (
  input logic                  clk,
  input logic                  rst,
  atm_display_driver_if.slave  bus
);
  localparam int unsigned REF_W  = $clog2(REFRESH_DIV);
  localparam int unsigned BEEP_W = $clog2(BEEP_CYCLES + 1);
  localparam int unsigned BAL_W  = 8;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned ITER_W = 3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  typedef enum logic [1:0] {CONV_IDLE, CONV_SHIFT, CONV_DONE} conv_state_e;

  // Decimal digit to active-low glyph; codes above 9 show a dash.
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // ---------------- converter ----------------
  conv_state_e       state_q, state_d;
  logic [BAL_W-1:0]  shift_q, shift_d;
  logic [BAL_W-1:0]  src_q, src_d;
  logic [BAL_W-1:0]  last_q, last_d;
  logic [BCD_W-1:0]  acc_q, acc_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              busy_q, busy_d;
  logic [BCD_W-1:0]  adj;

  // Converter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CONV_IDLE;
      shift_q <= '0;
      src_q   <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      disp_q  <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      src_q   <= src_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      disp_q  <= disp_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
    end
  end

  // Converter next-state logic; display regs only change in CONV_DONE.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    src_d   = src_q;
    last_d  = last_q;
    acc_d   = acc_q;
    disp_d  = disp_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    adj     = add3(acc_q);
    case (state_q)
      CONV_IDLE: begin
        if (bus.balance != last_q) begin
          shift_d = bus.balance;
          src_d   = bus.balance;
          acc_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        acc_d   = {adj[BCD_W-2:0], shift_q[BAL_W-1]};
        shift_d = {shift_q[BAL_W-2:0], 1'b0};
        iter_d  = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(BAL_W - 1)) state_d = CONV_DONE;
      end
      CONV_DONE: begin
        disp_d  = acc_q;
        last_d  = src_q;
        busy_d  = 1'b0;
        state_d = CONV_IDLE;
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  // ---------------- digit scan ----------------
  logic [REF_W-1:0] ref_cnt;
  logic [1:0]       digit_idx;
  logic [3:0]       an_q, an_c;
  logic [6:0]       seg_q, seg_c;
  logic             dp_q;

  // Content for the digit currently selected by digit_idx.
  always_comb begin
    an_c  = ~(4'b0001 << digit_idx);
    seg_c = SEG_BLANK;
    if (bus.preview_active) begin
      case (digit_idx)
        2'd3:    seg_c = SEG_P;
        2'd0:    seg_c = digit_glyph(bus.seg_value);
        default: seg_c = SEG_BLANK;
      endcase
    end else begin
      case (digit_idx)
        2'd2:    seg_c = digit_glyph(disp_q[11:8]);
        2'd1:    seg_c = digit_glyph(disp_q[7:4]);
        2'd0:    seg_c = digit_glyph(disp_q[3:0]);
        default: seg_c = SEG_BLANK;
      endcase
`ifdef ATM_DISP_ZERO_BLANK_EN
      if (digit_idx == 2'd2 && disp_q[11:8] == 4'd0) seg_c = SEG_BLANK;
      if (digit_idx == 2'd1 && disp_q[11:4] == 8'd0) seg_c = SEG_BLANK;
`endif
    end
  end

  // Refresh divider and registered an/seg, updated together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt   <= '0;
      digit_idx <= '0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      an_q  <= an_c;
      seg_q <= seg_c;
      dp_q  <= 1'b1;
      if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
        ref_cnt   <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + REF_W'(1);
      end
    end
  end

  // ---------------- beep stretcher ----------------
  logic              beep_q;
  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
  logic              buzzer_q;

  // Rising edge reloads; otherwise count down to zero.
  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if (bus.beep && !beep_q) beep_cnt_d = BEEP_W'(BEEP_CYCLES);
    else if (beep_cnt_q != '0) beep_cnt_d = beep_cnt_q - BEEP_W'(1);
  end

  // buzzer registered from the next count so it tracks count != 0 exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
      buzzer_q   <= 1'b0;
    end else begin
      beep_q     <= bus.beep;
      beep_cnt_q <= beep_cnt_d;
      buzzer_q   <= (beep_cnt_d != '0);
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.buzzer    = buzzer_q;
  assign bus.conv_busy = busy_q;
endmodule

// File: tb/tb_atm_display_driver.sv
// tb_atm_display_driver: self-checking bench for atm_display_driver with
// REFRESH_DIV=4, BEEP_CYCLES=5. Expected values come from decimal arithmetic
// on the balance, an edge-count scan model and a last-rising-edge beep model.
module tb_atm_display_driver;
  localparam int unsigned RDIV  = 4;
  localparam int unsigned BEEPC = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atm_display_driver_if bus();

  atm_display_driver #(.REFRESH_DIV(RDIV), .BEEP_CYCLES(BEEPC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt;
  int shown;

  // Clock edges since reset release; drives the scan-slot model.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic int slot_of(input int ec);
    return ((ec - 1) / RDIV) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int ec);
    logic [3:0] one;
    one = 4'b0001;
    if (ec == 0) return 4'b1111;
    return ~(one << slot_of(ec));
  endfunction

  function automatic logic [6:0] exp_seg(input int ec, input bit prev, input int sv, input int val);
    int idx, h, t, o;
    if (ec == 0) return 7'b1111111;
    idx = slot_of(ec);
    if (prev) begin
      if (idx == 3) return 7'b0001100;
      if (idx == 0) return (sv <= 9) ? glyph(sv) : 7'b0111111;
      return 7'b1111111;
    end
    h = val / 100;
    t = (val / 10) % 10;
    o = val % 10;
    if (idx == 3) return 7'b1111111;
`ifdef ATM_DISP_ZERO_BLANK_EN
    if (idx == 2 && h == 0) return 7'b1111111;
    if (idx == 1 && h == 0 && t == 0) return 7'b1111111;
`endif
    if (idx == 2) return glyph(h);
    if (idx == 1) return glyph(t);
    return glyph(o);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.balance = 8'd0;
    bus.seg_value = 4'd0;
    bus.preview_active = 1'b0;
    bus.beep = 1'b0;
    shown = 0;
    #12;
    n_cmp++;
    if ({bus.an, bus.seg, bus.dp, bus.buzzer, bus.conv_busy} !== {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values got an=%b seg=%b dp=%b buz=%b busy=%b", bus.an, bus.seg, bus.dp, bus.buzzer, bus.conv_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.an !== exp_an(edge_cnt)) begin
        n_bad++;
        $display("FAIL reset_scan_an k=%0d got %b exp %b", k, bus.an, exp_an(edge_cnt));
      end
      n_cmp++;
      if (bus.seg !== exp_seg(edge_cnt, 1'b0, 0, 0)) begin
        n_bad++;
        $display("FAIL reset_scan_seg k=%0d got %b exp %b", k, bus.seg, exp_seg(edge_cnt, 1'b0, 0, 0));
      end
      n_cmp++;
      if (bus.conv_busy !== 1'b0 || bus.dp !== 1'b1 || bus.buzzer !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle k=%0d got busy=%b dp=%b buz=%b exp 0 1 0", k, bus.conv_busy, bus.dp, bus.buzzer);
      end
    end
  endtask

  task automatic test_conversion();
    int vals[$];
    int v, old;
    vals = '{200, 0, 255, 100, 9};
    for (int i = 0; i < 5; i++) vals.push_back(int'($urandom_range(255, 0)));
    @(negedge clk);
    foreach (vals[i]) begin
      v = vals[i];
      if (v == shown) v = (v + 1) % 256;
      old = shown;
      bus.balance = 8'(v);
      for (int k = 0; k < 26; k++) begin
        @(negedge clk);
        n_cmp++;
        if (bus.conv_busy !== (k <= 8)) begin
          n_bad++;
          $display("FAIL conv_busy val=%0d k=%0d got %b exp %b", v, k, bus.conv_busy, (k <= 8));
        end
        n_cmp++;
        if (bus.an !== exp_an(edge_cnt)) begin
          n_bad++;
          $display("FAIL conv_an val=%0d k=%0d got %b exp %b", v, k, bus.an, exp_an(edge_cnt));
        end
        n_cmp++;
        if (bus.seg !== exp_seg(edge_cnt, 1'b0, 0, (k <= 9) ? old : v)) begin
          n_bad++;
          $display("FAIL conv_seg val=%0d k=%0d got %b exp %b", v, k, bus.seg, exp_seg(edge_cnt, 1'b0, 0, (k <= 9) ? old : v));
        end
      end
      shown = v;
    end
  endtask

  task automatic test_preview();
    int svs[$];
    svs = '{3, 12, 9, 15};
    for (int i = 0; i < 3; i++) svs.push_back(int'($urandom_range(15, 0)));
    @(negedge clk);
    bus.preview_active = 1'b1;
    foreach (svs[i]) begin
      bus.seg_value = 4'(svs[i]);
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        n_cmp++;
        if (bus.seg !== exp_seg(edge_cnt, 1'b1, svs[i], shown) || bus.an !== exp_an(edge_cnt)) begin
          n_bad++;
          $display("FAIL preview sv=%0d k=%0d got an=%b seg=%b exp an=%b seg=%b", svs[i], k, bus.an, bus.seg,
                   exp_an(edge_cnt), exp_seg(edge_cnt, 1'b1, svs[i], shown));
        end
      end
    end
    bus.preview_active = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.seg !== exp_seg(edge_cnt, 1'b0, 0, shown)) begin
        n_bad++;
        $display("FAIL preview_exit k=%0d got %b exp %b", k, bus.seg, exp_seg(edge_cnt, 1'b0, 0, shown));
      end
    end
  endtask

  task automatic test_midconv_change();
    int old, e;
    @(negedge clk);
    if (shown == 255 || shown == 7) begin
      bus.balance = 8'd1;
      repeat (15) @(negedge clk);
      shown = 1;
    end
    old = shown;
    bus.balance = 8'd255;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      e = (k <= 9) ? old : ((k <= 19) ? 255 : 7);
      n_cmp++;
      if (bus.conv_busy !== ((k <= 8) || (k >= 10 && k <= 18))) begin
        n_bad++;
        $display("FAIL midconv_busy k=%0d got %b", k, bus.conv_busy);
      end
      n_cmp++;
      if (bus.seg !== exp_seg(edge_cnt, 1'b0, 0, e)) begin
        n_bad++;
        $display("FAIL midconv_seg k=%0d got %b exp %b", k, bus.seg, exp_seg(edge_cnt, 1'b0, 0, e));
      end
      if (k == 2) bus.balance = 8'd7;
    end
    shown = 7;
  endtask

  task automatic test_beep();
    bit b[$];
    bit prev;
    int last_rise;
    logic exp_b;
    b = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 80; i++) b.push_back($urandom_range(99, 0) < 30);
    for (int i = 0; i < 8; i++) b.push_back(1'b0);
    prev = 1'b0;
    last_rise = -1000;
    @(negedge clk);
    foreach (b[j]) begin
      bus.beep = b[j];
      @(negedge clk);
      if (b[j] && !prev) last_rise = j;
      prev = b[j];
      exp_b = ((j - last_rise) < int'(BEEPC));
      n_cmp++;
      if (bus.buzzer !== exp_b) begin
        n_bad++;
        $display("FAIL buzzer j=%0d got %b exp %b", j, bus.buzzer, exp_b);
      end
    end
    bus.beep = 1'b0;
  endtask

  task automatic test_reset_midconv();
    int x;
    @(negedge clk);
    x = int'($urandom_range(255, 1));
    if (x == shown) x = (x % 255) + 1;
    bus.balance = 8'(x);
    bus.beep = 1'b1;
    @(negedge clk);
    bus.beep = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.an, bus.seg, bus.dp, bus.buzzer, bus.conv_busy} !== {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL midconv_reset got an=%b seg=%b dp=%b buz=%b busy=%b", bus.an, bus.seg, bus.dp, bus.buzzer, bus.conv_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    shown = 0;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.conv_busy !== (k <= 8) || bus.buzzer !== 1'b0) begin
        n_bad++;
        $display("FAIL reconv_busy k=%0d got busy=%b buz=%b exp busy=%b buz=0", k, bus.conv_busy, bus.buzzer, (k <= 8));
      end
      n_cmp++;
      if (bus.seg !== exp_seg(edge_cnt, 1'b0, 0, (k <= 9) ? 0 : x) || bus.an !== exp_an(edge_cnt)) begin
        n_bad++;
        $display("FAIL reconv_disp val=%0d k=%0d got an=%b seg=%b exp an=%b seg=%b", x, k, bus.an, bus.seg,
                 exp_an(edge_cnt), exp_seg(edge_cnt, 1'b0, 0, (k <= 9) ? 0 : x));
      end
    end
    shown = x;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_conversion();
    test_preview();
    test_midconv_change();
    test_beep();
    test_reset_midconv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
